// File: rtl/replay_writer_if.sv
// Replay restore bus: replay stream from control, backup RF read port,
// core RF write port and restore status. The slave view belongs to
// replay_writer; the master view belongs to whatever drives and observes it.
interface replay_writer_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    // Replay stream from control
    logic                  fetch_block_i;
    logic [ADDR_WIDTH-1:0] replay_addr_i;

    // Backup register file read port
    logic                  bkp_re_o;
    logic [ADDR_WIDTH-1:0] bkp_raddr_o;
    logic [DATA_WIDTH-1:0] bkp_rdata_i;

    // Core register file write port
    logic                  rf_we_o;
    logic [ADDR_WIDTH-1:0] rf_waddr_o;
    logic [DATA_WIDTH-1:0] rf_wdata_o;

    // Restore status
    logic                  restore_done_o;
    logic                  seq_error_o;
    logic [ADDR_WIDTH:0]   restore_count_o;

    modport slave (
        input  fetch_block_i,
        input  replay_addr_i,
        input  bkp_rdata_i,
        output bkp_re_o,
        output bkp_raddr_o,
        output rf_we_o,
        output rf_waddr_o,
        output rf_wdata_o,
        output restore_done_o,
        output seq_error_o,
        output restore_count_o
    );

    modport master (
        output fetch_block_i,
        output replay_addr_i,
        output bkp_rdata_i,
        input  bkp_re_o,
        input  bkp_raddr_o,
        input  rf_we_o,
        input  rf_waddr_o,
        input  rf_wdata_o,
        input  restore_done_o,
        input  seq_error_o,
        input  restore_count_o
    );
endinterface

// File: rtl/replay_writer.sv
// Register-restore responder. Each replayed address is looked up in the
// backup register file (synchronous read) and written into the core register
// file one cycle later. The address sequence is checked against 0,1,2,...
// and the number of accepted addresses is counted, saturating at NUM_REG.
module replay_writer #(
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REG    = 2 ** ADDR_WIDTH,
    parameter int DATA_WIDTH = 32,
    parameter int SKIP_ZERO  = 1
) (
    input  logic            clk,
    input  logic            rst,
    replay_writer_if.slave  bus
);
    localparam logic [ADDR_WIDTH:0] NUM_REG_C = (ADDR_WIDTH + 1)'(NUM_REG);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RESTORE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  stage_valid_q, stage_valid_d;
    logic [ADDR_WIDTH-1:0] stage_addr_q, stage_addr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  seq_error_q, seq_error_d;

    logic                  capture;
    logic                  start;
    logic [ADDR_WIDTH-1:0] expected_addr;
    logic                  addr_bad;
    logic                  count_full;

    // A capture outside RESTORE begins a fresh restore; inside RESTORE the
    // expected address is simply the count folded back into address range.
    assign capture       = bus.fetch_block_i;
    assign start         = capture && (state_q != ST_RESTORE);
    assign expected_addr = count_q[ADDR_WIDTH-1:0];
    assign count_full    = (count_q >= NUM_REG_C);
    assign addr_bad      = (bus.replay_addr_i != expected_addr) || count_full;

    // Next-state, capture stage, counter and sticky error flag
    always_comb begin
        state_d       = state_q;
        stage_valid_d = capture;
        stage_addr_d  = stage_addr_q;
        count_d       = count_q;
        seq_error_d   = seq_error_q;

        if (capture) begin
            stage_addr_d = bus.replay_addr_i;
        end

        if (start) begin
            // A new restore always expects address 0 first.
            count_d     = {{ADDR_WIDTH{1'b0}}, 1'b1};
            seq_error_d = (bus.replay_addr_i != '0);
        end else if (capture) begin
            if (!count_full) begin
                count_d = count_q + 1'b1;
            end
            if (addr_bad) begin
                seq_error_d = 1'b1;
            end
        end

        unique case (state_q)
            ST_IDLE:    state_d = capture ? ST_RESTORE : ST_IDLE;
            ST_RESTORE: state_d = capture ? ST_RESTORE : ST_DONE;
            ST_DONE:    state_d = capture ? ST_RESTORE : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // State register; reset drops any staged write immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            stage_valid_q <= 1'b0;
            stage_addr_q  <= '0;
            count_q       <= '0;
            seq_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            stage_valid_q <= stage_valid_d;
            stage_addr_q  <= stage_addr_d;
            count_q       <= count_d;
            seq_error_q   <= seq_error_d;
        end
    end

    // Backup RF read is issued straight from the replay stream so its data
    // lines up with the staged address one cycle later.
    assign bus.bkp_re_o    = bus.fetch_block_i;
    assign bus.bkp_raddr_o = bus.replay_addr_i;

    // x0 is hardwired in the core, so with SKIP_ZERO its write is suppressed
    // even though the address still counts towards the restore.
    assign bus.rf_we_o    = stage_valid_q &&
                            !((SKIP_ZERO != 0) && (stage_addr_q == '0));
    assign bus.rf_waddr_o = stage_addr_q;
    assign bus.rf_wdata_o = bus.bkp_rdata_i;

    assign bus.restore_done_o  = (state_q == ST_DONE);
    assign bus.seq_error_o     = seq_error_q;
    assign bus.restore_count_o = count_q;
endmodule

// File: tb/tb_replay_writer.sv
// Bench for replay_writer: two instances (SKIP_ZERO=1 and 0) share one
// replay stream, each with its own backup RF model and write scoreboard.
module tb_replay_writer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fetch = 1'b0;
    logic [4:0] addr = '0;

    int errors = 0;
    int checks = 0;
    int wr0 = 0;
    int wr1 = 0;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;
    wr_t q0[$];
    wr_t q1[$];

    always #5 clk = ~clk;

    replay_writer_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) if0 ();
    replay_writer_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) if1 ();

    assign if0.fetch_block_i = fetch;
    assign if0.replay_addr_i = addr;
    assign if1.fetch_block_i = fetch;
    assign if1.replay_addr_i = addr;

    replay_writer #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .SKIP_ZERO(1)) dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave));
    replay_writer #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .SKIP_ZERO(0)) dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave));

    // Backup register file models: synchronous read, data tagged with address
    always @(posedge clk) begin
        if (if0.bkp_re_o) if0.bkp_rdata_i <= 32'hA500_0000 | {27'd0, if0.bkp_raddr_o};
        if (if1.bkp_re_o) if1.bkp_rdata_i <= 32'hA500_0000 | {27'd0, if1.bkp_raddr_o};
    end

    // Write monitors: every core RF write must match the scoreboard head
    always @(posedge clk) begin
        #3;
        if (if0.rf_we_o) begin
            wr0++;
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL wr0_unexpected: got addr=%0d data=%h, required no write",
                         if0.rf_waddr_o, if0.rf_wdata_o);
            end else begin
                wr_t e;
                e = q0.pop_front();
                if (if0.rf_waddr_o !== e.a || if0.rf_wdata_o !== e.d) begin
                    errors++;
                    $display("FAIL wr0_data: got addr=%0d data=%h, required addr=%0d data=%h",
                             if0.rf_waddr_o, if0.rf_wdata_o, e.a, e.d);
                end
            end
        end
        if (if1.rf_we_o) begin
            wr1++;
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL wr1_unexpected: got addr=%0d data=%h, required no write",
                         if1.rf_waddr_o, if1.rf_wdata_o);
            end else begin
                wr_t e;
                e = q1.pop_front();
                if (if1.rf_waddr_o !== e.a || if1.rf_wdata_o !== e.d) begin
                    errors++;
                    $display("FAIL wr1_data: got addr=%0d data=%h, required addr=%0d data=%h",
                             if1.rf_waddr_o, if1.rf_wdata_o, e.a, e.d);
                end
            end
        end
    end

    // One cycle of stimulus; returns 1 time unit after the capturing edge
    task automatic cyc(input logic fb, input logic [4:0] a);
        @(negedge clk);
        fetch = fb;
        addr  = a;
        if (fb) begin
            wr_t e;
            e.a = a;
            e.d = 32'hA500_0000 | {27'd0, a};
            if (a != 5'd0) q0.push_back(e);
            q1.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_queues(input string tag);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: got q0=%0d q1=%0d outstanding writes, required 0 0",
                     tag, q0.size(), q1.size());
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        fetch = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (if0.rf_we_o !== 1'b0 || if0.rf_waddr_o !== 5'd0 || if0.restore_count_o !== 6'd0 ||
            if0.seq_error_o !== 1'b0 || if0.restore_done_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got we=%b waddr=%0d cnt=%0d err=%b done=%b, required 0 0 0 0 0",
                     if0.rf_we_o, if0.rf_waddr_o, if0.restore_count_o, if0.seq_error_o, if0.restore_done_o);
        end
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 5'd0);
        checks++;
        if (if0.restore_done_o !== 1'b0 || if0.rf_we_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got done=%b we=%b, required 0 0",
                     if0.restore_done_o, if0.rf_we_o);
        end
    endtask

    task automatic test_full_replay();
        wr0 = 0;
        wr1 = 0;
        for (int i = 0; i < 32; i++) cyc(1'b1, 5'(i));
        checks++;
        if (if0.restore_count_o !== 6'd32 || if1.restore_count_o !== 6'd32) begin
            errors++;
            $display("FAIL full_count: got %0d/%0d, required 32", if0.restore_count_o, if1.restore_count_o);
        end
        cyc(1'b0, 5'd0);
        checks++;
        if (if0.restore_done_o !== 1'b1 || if0.seq_error_o !== 1'b0 || if0.restore_count_o !== 6'd32) begin
            errors++;
            $display("FAIL full_done: got done=%b err=%b cnt=%0d, required 1 0 32",
                     if0.restore_done_o, if0.seq_error_o, if0.restore_count_o);
        end
        cyc(1'b0, 5'd0);
        checks++;
        if (if0.restore_done_o !== 1'b0) begin
            errors++;
            $display("FAIL full_done_pulse: got done=%b one cycle later, required 0", if0.restore_done_o);
        end
        checks++;
        if (wr0 != 31 || wr1 != 32) begin
            errors++;
            $display("FAIL full_writes: got %0d (skip) %0d (noskip), required 31 32", wr0, wr1);
        end
        check_queues("full");
    endtask

    task automatic test_seq_violation();
        logic [4:0] seq [5];
        seq = '{5'd0, 5'd1, 5'd2, 5'd4, 5'd5};
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, seq[i]);
            checks++;
            if (if0.seq_error_o !== (i >= 3)) begin
                errors++;
                $display("FAIL seq_flag: got err=%b after addr %0d, required %b",
                         if0.seq_error_o, seq[i], (i >= 3));
            end
        end
        cyc(1'b0, 5'd0);
        checks++;
        if (if0.restore_done_o !== 1'b1 || if0.seq_error_o !== 1'b1) begin
            errors++;
            $display("FAIL seq_done: got done=%b err=%b, required 1 1",
                     if0.restore_done_o, if0.seq_error_o);
        end
        cyc(1'b0, 5'd0);
        cyc(1'b1, 5'd0);
        checks++;
        if (if0.seq_error_o !== 1'b0 || if0.restore_count_o !== 6'd1) begin
            errors++;
            $display("FAIL seq_clear: got err=%b cnt=%0d, required 0 1",
                     if0.seq_error_o, if0.restore_count_o);
        end
        cyc(1'b0, 5'd0);
        cyc(1'b0, 5'd0);
        check_queues("seq");
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 32; i++) cyc(1'b1, 5'(i));
        checks++;
        if (if0.seq_error_o !== 1'b0) begin
            errors++;
            $display("FAIL ovr_before: got err=%b after 32 captures, required 0", if0.seq_error_o);
        end
        cyc(1'b1, 5'd0);
        checks++;
        if (if0.seq_error_o !== 1'b1 || if0.restore_count_o !== 6'd32) begin
            errors++;
            $display("FAIL ovr_33rd: got err=%b cnt=%0d, required 1 32",
                     if0.seq_error_o, if0.restore_count_o);
        end
        cyc(1'b0, 5'd0);
        cyc(1'b0, 5'd0);
        check_queues("ovr");
    endtask

    task automatic test_reset_mid_restore();
        for (int i = 0; i < 10; i++) cyc(1'b1, 5'(i));
        @(negedge clk);
        fetch = 1'b1;
        addr  = 5'd10;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (if0.rf_we_o !== 1'b0 || if1.rf_we_o !== 1'b0 || if0.restore_count_o !== 6'd0 ||
            if0.rf_waddr_o !== 5'd0 || if0.restore_done_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: got we=%b/%b cnt=%0d waddr=%0d done=%b, required 0/0 0 0 0",
                     if0.rf_we_o, if1.rf_we_o, if0.restore_count_o, if0.rf_waddr_o, if0.restore_done_o);
        end
        @(negedge clk);
        fetch = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 5'd0);
            checks++;
            if (if0.restore_done_o !== 1'b0) begin
                errors++;
                $display("FAIL rst_no_done: got done=%b after reset, required 0", if0.restore_done_o);
            end
        end
        check_queues("rst_mid");
        wr0 = 0;
        wr1 = 0;
        for (int i = 0; i < 32; i++) cyc(1'b1, 5'(i));
        cyc(1'b0, 5'd0);
        checks++;
        if (if0.restore_done_o !== 1'b1 || if0.seq_error_o !== 1'b0 || if0.restore_count_o !== 6'd32) begin
            errors++;
            $display("FAIL rst_rerun: got done=%b err=%b cnt=%0d, required 1 0 32",
                     if0.restore_done_o, if0.seq_error_o, if0.restore_count_o);
        end
        cyc(1'b0, 5'd0);
        checks++;
        if (wr0 != 31 || wr1 != 32) begin
            errors++;
            $display("FAIL rst_rerun_writes: got %0d %0d, required 31 32", wr0, wr1);
        end
        check_queues("rst_rerun");
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 4; i++) cyc(1'b1, 5'(i));
        cyc(1'b0, 5'd0);
        if (if0.restore_done_o === 1'b1) pulses++;
        cyc(1'b1, 5'd0);
        if (if0.restore_done_o === 1'b1) pulses++;
        checks++;
        if (if0.restore_count_o !== 6'd1 || if0.seq_error_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_reload: got cnt=%0d err=%b, required 1 0",
                     if0.restore_count_o, if0.seq_error_o);
        end
        cyc(1'b1, 5'd1);
        if (if0.restore_done_o === 1'b1) pulses++;
        checks++;
        if (pulses != 1 || if0.restore_count_o !== 6'd2 || if0.seq_error_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_pulse: got pulses=%0d cnt=%0d err=%b, required 1 2 0",
                     pulses, if0.restore_count_o, if0.seq_error_o);
        end
        cyc(1'b0, 5'd0);
        checks++;
        if (if0.restore_done_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_end: got done=%b, required 1", if0.restore_done_o);
        end
        cyc(1'b0, 5'd0);
        check_queues("b2b");
    endtask

    initial begin
        test_reset();
        test_full_replay();
        test_seq_violation();
        test_overrun();
        test_reset_mid_restore();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/replay_writer.md
# replay_writer

Register-restore responder for the fault-tolerant core. It consumes the replay stream from `control`: `fetch_block` acts as valid and `replay_addr` steps through register addresses. For each address it reads the checkpointed value from the backup register file and writes it into the core register file one cycle later. It checks the address sequence, counts restored registers and signals completion to the rest of the recovery logic.

## Interface
- `ADDR_WIDTH`, 5, register address width; must match `control`.
- `NUM_REG`, 2**ADDR_WIDTH, registers per full restore.
- `DATA_WIDTH`, 32, register data width.
- `SKIP_ZERO`, 1, when 1 address 0 is accepted and counted but never written (x0 hardwired).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `fetch_block_i`  in  1  replay valid from `control`.
- `replay_addr_i`  in  ADDR_WIDTH  replay address from `control`.
- `bkp_re_o`  out  1  backup RF read enable, combinational = `fetch_block_i`.
- `bkp_raddr_o`  out  ADDR_WIDTH  backup RF read address, combinational = `replay_addr_i`.
- `bkp_rdata_i`  in  DATA_WIDTH  backup RF data; synchronous read, valid the cycle after the address.
- `rf_we_o`  out  1  core RF write enable.
- `rf_waddr_o`  out  ADDR_WIDTH  core RF write address.
- `rf_wdata_o`  out  DATA_WIDTH  core RF write data, combinational = `bkp_rdata_i`.
- `restore_done_o`  out  1  one-cycle pulse at end of a restore.
- `seq_error_o`  out  1  sticky sequence-violation flag.
- `restore_count_o`  out  ADDR_WIDTH+1  addresses accepted in the current or last restore.

## Operation
- States: IDLE, RESTORE, DONE.
- Capture: any rising edge with `fetch_block_i`=1, in any state.
  - Registers stage_valid=1 and stage_addr=`replay_addr_i`.
  - Increments count, saturating at NUM_REG.
  - Edges with `fetch_block_i`=0 clear stage_valid.
- Start of restore: a capture in IDLE or DONE.
  - Count loads 1 and `seq_error_o` clears.
  - Address is checked against expected=0.
  - Next state RESTORE.
- In RESTORE, each capture checks `replay_addr_i` == expected (expected = count mod NUM_REG) and count < NUM_REG.
  - Any failure sets `seq_error_o`, which holds until the next start.
  - The write is still performed.
- Transitions:
  - RESTORE with `fetch_block_i`=0 at an edge goes to DONE.
  - DONE always leaves after one cycle: to RESTORE (new start) if `fetch_block_i`=1, else IDLE.
  - IDLE with `fetch_block_i`=0 stays IDLE.
- Write stage:
  - `rf_we_o` = stage_valid AND NOT (SKIP_ZERO AND stage_addr==0).
  - `rf_waddr_o` = stage_addr.
- `restore_done_o` = (state==DONE); Moore output, asserted whether or not `seq_error_o` is set.
- Address wrap: expected wraps mod NUM_REG. A 33rd capture is flagged by count saturation even if its address is 0.
- Reset (async, any time including mid-restore):
  - state IDLE, stage_valid 0, count 0, `seq_error_o` 0, `restore_done_o` 0.
  - `rf_we_o` 0 and `rf_waddr_o` 0 immediately.
  - A pending write is discarded.

## Timing
- Write latency: 1 cycle. Address captured at edge N is written in the cycle between edges N and N+1, using `bkp_rdata_i` returned for that address.
- `restore_count_o` and `seq_error_o` reflect a capture from the edge it occurs on.
- Full restore with `fetch_block_i` high for edges E0..E31 and low at E32:
  - Writes occur in cycles E0..E31.
  - `restore_done_o` is high from E32 to E33.
  - `restore_count_o`=32 from E31.
- A single-cycle gap in `fetch_block_i` ends the restore: DONE pulses, and re-assertion starts a new restore that expects address 0.
- Throughput: one register per cycle; no backpressure.

## Test plan
- Full replay: reset, then `fetch_block_i` high 32 cycles with addresses 0..31; backup model returns 0xA500_0000|addr.
  - Required: 31 writes, addresses 1..31 with matching data; no write to 0.
  - Required: `restore_done_o` 1 cycle after last write; count=32; `seq_error_o`=0.
- SKIP_ZERO=0 with the same stimulus.
  - Required: 32 writes including address 0 with data 0xA500_0000.
- Sequence violation: addresses 0,1,2,4,5.
  - Required: `seq_error_o` rises at the edge capturing 4 and stays 1 through DONE.
  - Required: address 4 is still written; the next start clears the flag.
- Overrun: 33 consecutive captures, addresses 0..31,0.
  - Required: `seq_error_o` set at the 33rd edge; count holds 32.
- Reset mid-restore: assert `rst` asynchronously after address 10 is captured.
  - Required: `rf_we_o`=0 and count=0 immediately; no write of address 10; no `restore_done_o`.
  - Required: the next replay restores normally.
- Back-to-back restores: `fetch_block_i` re-asserted in the DONE cycle.
  - Required: DONE pulses once; count reloads 1; address 0 is expected.
